// File: rtl/mc_control.sv
// Multicycle control FSM for the brimstone datapath: sequences fetch/decode/execute/memory/writeback.
// Optional: define BRIMSTONE_BNE_EN to decode opcode 000101 (bne) into BNEEX.
module mc_control #(
    parameter int DATA_WIDTH_P  = 32,
    parameter int CNTRL_WIDTH_P = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               i_op,
    input  logic [5:0]               i_funct,
    input  logic                     i_zero,
    input  logic                     i_mem_ready,
    output logic [CNTRL_WIDTH_P-1:0] o_alu_control,
    output logic                     o_alu_src_a,
    output logic [1:0]               o_alu_src_b,
    output logic [1:0]               o_pc_src,
    output logic                     o_pc_en,
    output logic                     o_ir_write,
    output logic                     o_iord,
    output logic                     o_mem_req,
    output logic                     o_mem_write,
    output logic                     o_reg_write,
    output logic                     o_reg_dst,
    output logic                     o_mem_to_reg,
    output logic                     o_illegal
);

    if (CNTRL_WIDTH_P != 3) begin : g_bad_cntrl
        $error("mc_control: CNTRL_WIDTH_P must be 3");
    end
    if (DATA_WIDTH_P < 1) begin : g_bad_data
        $error("mc_control: DATA_WIDTH_P must be positive");
    end

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef BRIMSTONE_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
`ifdef BRIMSTONE_BNE_EN
        , BNEEX
`endif
    } state_t;

    state_t     state;
    logic       op_legal;
    logic       funct_legal;
    logic [2:0] funct_alu;

    always_comb begin
        op_legal = 1'b0;
        case (i_op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef BRIMSTONE_BNE_EN
            OP_BNE: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (i_funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (i_mem_ready) state <= DECODE;
                DECODE: begin
                    case (i_op)
                        OP_R:         state <= RTYPEEX;
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
`ifdef BRIMSTONE_BNE_EN
                        OP_BNE:       state <= BNEEX;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                // IR still holds the opcode here, so it selects load vs store.
                MEMADR:  state <= (i_op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (i_mem_ready) state <= MEMWB;
                MEMWR:   if (i_mem_ready) state <= FETCH;
                RTYPEEX: state <= funct_legal ? RTYPEWB : FETCH;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        o_alu_control = ALU_ADD;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_pc_src      = 2'b00;
        o_pc_en       = 1'b0;
        o_ir_write    = 1'b0;
        o_iord        = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_write   = 1'b0;
        o_reg_write   = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_illegal     = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    o_mem_req   = 1'b1;
                    o_alu_src_b = 2'b01;
                    o_ir_write  = i_mem_ready;
                    o_pc_en     = i_mem_ready;
                end
                DECODE: begin
                    o_alu_src_b = 2'b11;
                    o_illegal   = ~op_legal;
                end
                MEMADR, ADDIEX: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'b10;
                end
                MEMRD: begin
                    o_mem_req = 1'b1;
                    o_iord    = 1'b1;
                end
                MEMWB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                end
                MEMWR: begin
                    o_mem_req   = 1'b1;
                    o_mem_write = 1'b1;
                    o_iord      = 1'b1;
                end
                RTYPEEX: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_control = funct_alu;
                    o_illegal     = ~funct_legal;
                end
                RTYPEWB: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = 1'b1;
                end
                BEQEX: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_control = ALU_SUB;
                    o_pc_src      = 2'b01;
                    o_pc_en       = i_zero;
                end
`ifdef BRIMSTONE_BNE_EN
                BNEEX: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_control = ALU_SUB;
                    o_pc_src      = 2'b01;
                    o_pc_en       = ~i_zero;
                end
`endif
                ADDIWB:  o_reg_write = 1'b1;
                JEX: begin
                    o_pc_src = 2'b10;
                    o_pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle expected output vectors queued and checked at negedge.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] i_op;
    logic [5:0] i_funct;
    logic       i_zero;
    logic       i_mem_ready;
    logic [2:0] o_alu_control;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_pc_src;
    logic       o_pc_en, o_ir_write, o_iord, o_mem_req, o_mem_write;
    logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal;

    int compared = 0;
    int mismatched = 0;
    logic [16:0] sb[$];
    logic [16:0] obs;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .reset(reset), .i_op(i_op), .i_funct(i_funct), .i_zero(i_zero),
        .i_mem_ready(i_mem_ready), .o_alu_control(o_alu_control), .o_alu_src_a(o_alu_src_a),
        .o_alu_src_b(o_alu_src_b), .o_pc_src(o_pc_src), .o_pc_en(o_pc_en),
        .o_ir_write(o_ir_write), .o_iord(o_iord), .o_mem_req(o_mem_req),
        .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_reg_dst(o_reg_dst),
        .o_mem_to_reg(o_mem_to_reg), .o_illegal(o_illegal)
    );

    assign obs = {o_alu_control, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_en, o_ir_write,
                  o_iord, o_mem_req, o_mem_write, o_reg_write, o_reg_dst, o_mem_to_reg, o_illegal};

    // {alu, src_a, src_b, pc_src, pc_en, ir_write, iord, mem_req, mem_write, reg_write, reg_dst, mem_to_reg, illegal}
    function automatic logic [16:0] pk(logic [2:0] alu, logic a, logic [1:0] b, logic [1:0] ps,
                                       logic pen, logic irw, logic iord, logic req, logic mw,
                                       logic rw, logic rd, logic m2r, logic ill);
        return {alu, a, b, ps, pen, irw, iord, req, mw, rw, rd, m2r, ill};
    endfunction

    function automatic logic [16:0] e_rst();          return pk(3'b010,0,2'b00,2'b00,0,0,0,0,0,0,0,0,0); endfunction
    function automatic logic [16:0] e_fetch(logic r); return pk(3'b010,0,2'b01,2'b00,r,r,0,1,0,0,0,0,0); endfunction
    function automatic logic [16:0] e_dec(logic ill); return pk(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0,0,ill); endfunction
    function automatic logic [16:0] e_addr();         return pk(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0); endfunction
    function automatic logic [16:0] e_memrd();        return pk(3'b010,0,2'b00,2'b00,0,0,1,1,0,0,0,0,0); endfunction
    function automatic logic [16:0] e_memwb();        return pk(3'b010,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0); endfunction
    function automatic logic [16:0] e_memwr();        return pk(3'b010,0,2'b00,2'b00,0,0,1,1,1,0,0,0,0); endfunction
    function automatic logic [16:0] e_rex(logic [2:0] alu, logic ill);
        return pk(alu,1,2'b00,2'b00,0,0,0,0,0,0,0,0,ill);
    endfunction
    function automatic logic [16:0] e_rwb();          return pk(3'b010,0,2'b00,2'b00,0,0,0,0,0,1,1,0,0); endfunction
    function automatic logic [16:0] e_br(logic t);    return pk(3'b110,1,2'b00,2'b01,t,0,0,0,0,0,0,0,0); endfunction
    function automatic logic [16:0] e_awb();          return pk(3'b010,0,2'b00,2'b00,0,0,0,0,0,1,0,0,0); endfunction
    function automatic logic [16:0] e_j();            return pk(3'b010,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0); endfunction

    // Queue the expectation for this cycle, compare at negedge, then advance past the next posedge.
    task automatic step(input logic [16:0] e, input string tag);
        logic [16:0] x;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        compared++;
        assert (obs === x) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] fn [5];
        logic [2:0] al [5];
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        reset = 1'b1; i_op = 6'b100011; i_funct = 6'b0; i_zero = 1'b0; i_mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(e_rst(), "reset_state");
        reset = 1'b0;

        // lw: 3 stall cycles in FETCH, 2 in MEMRD -> 10 cycles
        i_op = 6'b100011; i_mem_ready = 1'b0;
        repeat (3) step(e_fetch(0), "lw_fetch_stall");
        i_mem_ready = 1'b1;
        step(e_fetch(1), "lw_fetch");
        step(e_dec(0), "lw_decode");
        step(e_addr(), "lw_memadr");
        i_mem_ready = 1'b0;
        repeat (2) step(e_memrd(), "lw_memrd_stall");
        i_mem_ready = 1'b1;
        step(e_memrd(), "lw_memrd");
        step(e_memwb(), "lw_memwb");

        // R-type sweep
        i_op = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            i_funct = fn[k];
            step(e_fetch(1), "r_fetch");
            step(e_dec(0), "r_decode");
            step(e_rex(al[k], 0), "r_exec_aluop");
            step(e_rwb(), "r_wb");
        end

        // R-type unknown funct
        i_funct = 6'b000000;
        step(e_fetch(1), "rbad_fetch");
        step(e_dec(0), "rbad_decode");
        step(e_rex(3'b010, 1), "rbad_illegal");

        // beq taken / not taken
        i_op = 6'b000100; i_zero = 1'b1;
        step(e_fetch(1), "beq1_fetch");
        step(e_dec(0), "beq1_decode");
        step(e_br(1), "beq_taken");
        i_zero = 1'b0;
        step(e_fetch(1), "beq0_fetch");
        step(e_dec(0), "beq0_decode");
        step(e_br(0), "beq_not_taken");

        // sw
        i_op = 6'b101011;
        step(e_fetch(1), "sw_fetch");
        step(e_dec(0), "sw_decode");
        step(e_addr(), "sw_memadr");
        step(e_memwr(), "sw_memwr");

        // addi
        i_op = 6'b001000;
        step(e_fetch(1), "addi_fetch");
        step(e_dec(0), "addi_decode");
        step(e_addr(), "addi_exec");
        step(e_awb(), "addi_wb");

        // j
        i_op = 6'b000010;
        step(e_fetch(1), "j_fetch");
        step(e_dec(0), "j_decode");
        step(e_j(), "j_exec");

        // bne opcode
        i_op = 6'b000101; i_zero = 1'b0;
        step(e_fetch(1), "bne_fetch");
`ifdef BRIMSTONE_BNE_EN
        step(e_dec(0), "bne_decode");
        step(e_br(1), "bne_taken");
`else
        step(e_dec(1), "bne_illegal");
`endif

        // unsupported opcode
        i_op = 6'b111111;
        step(e_fetch(1), "ill_fetch");
        step(e_dec(1), "ill_decode");

        // reset in MEMRD with a request outstanding
        i_op = 6'b100011;
        step(e_fetch(1), "rst_lw_fetch");
        step(e_dec(0), "rst_lw_decode");
        step(e_addr(), "rst_lw_memadr");
        i_mem_ready = 1'b0;
        step(e_memrd(), "rst_lw_memrd");
        reset = 1'b1;
        step(e_rst(), "reset_mid_memrd");
        reset = 1'b0;
        step(e_fetch(0), "post_reset_fetch");
        i_mem_ready = 1'b1;
        step(e_fetch(1), "post_reset_fetch_rdy");
        step(e_dec(0), "post_reset_decode");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the brimstone datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback for each instruction. It is the producer side of the ALU control interface, turning opcode/funct into the 3-bit ALU operation code plus all datapath mux selects and write enables. It sits between the instruction register and the datapath, and stalls on a simple memory request/ready handshake.

## Interface
- DATA_WIDTH_P, 32, datapath width; documentation only, no ports depend on it
- CNTRL_WIDTH_P, 3, ALU control code width; must be 3
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- i_op  input  6  instruction opcode, bits [31:26] of the IR
- i_funct  input  6  R-type funct, IR bits [5:0]
- i_zero  input  1  ALU zero flag
- i_mem_ready  input  1  memory completes the current request this cycle
- o_alu_control  output  CNTRL_WIDTH_P  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- o_alu_src_a  output  1  0 = PC, 1 = register A
- o_alu_src_b  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- o_pc_src  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- o_pc_en  output  1  PC load enable, including branch qualification
- o_ir_write  output  1  IR load
- o_iord  output  1  0 = PC address, 1 = ALUOut address
- o_mem_req  output  1  memory access requested
- o_mem_write  output  1  request is a write
- o_reg_write, o_reg_dst, o_mem_to_reg  output  1 each  register file write, 0=rt/1=rd, 0=ALUOut/1=MDR
- o_illegal  output  1  single-cycle pulse on an unsupported opcode or funct

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX.
- Outputs are decoded from the state register. o_alu_control in RTYPEEX also depends on i_funct, and o_pc_en, o_ir_write and o_mem_req-gated strobes depend on i_zero and i_mem_ready.
- Unlisted outputs are 0. The default for o_alu_control is 010.
- FETCH: mem_req=1, iord=0, src_a=0, src_b=01, add, pc_src=00; ir_write=pc_en=i_mem_ready. Moves to DECODE on ready, otherwise holds.
- DECODE: src_a=0, src_b=11, add (branch target into ALUOut). Next state by i_op:
  - 000000 -> RTYPEEX
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - 000101 -> BNEEX (macro only)
  - anything else -> o_illegal=1, then FETCH
- MEMADR: src_a=1, src_b=10, add. Goes to MEMRD for lw, MEMWR for sw, using i_op as held by the IR.
- MEMRD: mem_req=1, iord=1; on ready -> MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1; on ready -> FETCH.
- RTYPEEX: src_a=1, src_b=00. i_funct maps to the ALU op: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Goes to RTYPEWB. An unknown funct gives o_illegal=1, ALU op 010, and goes to FETCH with no writeback.
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BEQEX: src_a=1, src_b=00, sub, pc_src=01, pc_en=i_zero -> FETCH.
- ADDIEX: src_a=1, src_b=10, add -> ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- JEX: pc_src=10, pc_en=1 -> FETCH.

## Timing
- Reset asserted: state=FETCH immediately. All enables are forced 0 while reset is high (pc_en, ir_write, mem_req, mem_write, reg_write, illegal). Selects read 0 and o_alu_control reads 010.
- Reset is accepted mid-instruction, including during an outstanding mem_req. The request drops the same cycle; no partial writeback occurs.
- First FETCH request appears in the first cycle after reset deasserts.
- Cycle counts with i_mem_ready=1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, bne, j: 3
  - illegal: 2
- Each cycle that i_mem_ready is low adds one cycle in FETCH/MEMRD/MEMWR. Outputs are held stable while stalled.
- The memory handshake completes in the cycle where o_mem_req and i_mem_ready are both 1. i_mem_ready is ignored when o_mem_req=0.

## Configuration
- BRIMSTONE_BNE_EN defined: opcode 000101 decodes to BNEEX. BNEEX is identical to BEQEX except pc_en = ~i_zero.
- BRIMSTONE_BNE_EN undefined: BNEEX does not exist, and 000101 takes the illegal path (o_illegal pulse in DECODE, back to FETCH).

## Test plan
- Reset mid-MEMRD with i_mem_ready=0: state returns to FETCH at once with all enables 0. After release, o_mem_req=1, o_iord=0 and o_alu_control=010 on the next cycle.
- R-type sweep with ready tied high, i_op=000000, i_funct ∈ {100000, 100010, 100100, 100101, 101010}: RTYPEEX shows o_alu_control = 010, 110, 000, 001, 111. RTYPEWB follows with reg_write=1 and reg_dst=1. 4 cycles per instruction.
- lw with i_mem_ready low for 3 cycles in FETCH and 2 in MEMRD: 10 cycles total. Exactly one ir_write pulse, one pc_en pulse in FETCH, and one reg_write with mem_to_reg=1.
- beq: i_zero=1 gives pc_en=1 with pc_src=01 and o_alu_control=110 in BEQEX; i_zero=0 gives pc_en=0. Both return to FETCH after 3 cycles.
- i_op=000101: with BRIMSTONE_BNE_EN, i_zero=0 gives a branch taken. Without it, o_illegal=1 for one cycle in DECODE and the next state is FETCH.
- R-type with i_funct=000000: o_illegal pulse in RTYPEEX, no reg_write, back in FETCH after 3 cycles.
